mnist_window_feeder: RTL and testbench

Hardware source for the simpleCNN image interface. It accepts one 28x28 8-bit MNIST image as a raster pixel stream and generates the 5x5 sliding windows (X, Y, IMGIN) plus a START pulse, in the order simpleCNN consumes them. It then blocks further input until simpleCNN reports DONE. This block replaces the testbench-side window generation in silicon and sits between the pixel source (DMA/UART loader) and simpleCNN.

---
 rtl/mnist_pkg.sv | 18 +
 rtl/line_buffer.sv | 33 +++
 rtl/mnist_window_feeder.sv | 120 ++++++++++++
 tb/tb_mnist_window_feeder.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mnist_pkg.sv
// Shared sizes and state encoding for the MNIST window feeder.
package mnist_pkg;

    localparam int unsigned IMG_W    = 28;
    localparam int unsigned IMG_H    = 28;
    localparam int unsigned K        = 5;
    localparam int unsigned PW       = 8;
    localparam int unsigned WIN_BITS = K * K * PW;
    localparam int unsigned POS_W    = 5;
    localparam int unsigned NWIN     = (IMG_W - K + 1) * (IMG_H - K + 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WAIT_DONE
    } state_t;

endpackage

// File: rtl/line_buffer.sv
// K-1 previous image rows, one column read and shifted per written pixel.
module line_buffer
    import mnist_pkg::*;
(
    input  logic                  CLK,
    input  logic                  we,
    input  logic [POS_W-1:0]      col,
    input  logic [PW-1:0]         pix,
    output logic [(K-1)*PW-1:0]   taps
);

    // mem[0] is the oldest row (r-4), mem[K-2] the most recent (r-1)
    logic [PW-1:0] mem [0:K-2][0:IMG_W-1];

    // Per-column vertical shift: the incoming pixel becomes the newest row entry
    always_ff @(posedge CLK) begin
        if (we) begin
            for (int j = 0; j < int'(K) - 2; j++) begin
                mem[j][col] <= mem[j+1][col];
            end
            mem[K-2][col] <= pix;
        end
    end

    // Read the prior-row pixels of the current column before the write lands
    always_comb begin
        taps = '0;
        for (int j = 0; j < int'(K) - 1; j++) begin
            taps[j*PW +: PW] = mem[j][col];
        end
    end

endmodule

// File: rtl/mnist_window_feeder.sv
// Turns a raster 28x28 pixel stream into 5x5 windows for simpleCNN.
module mnist_window_feeder
    import mnist_pkg::*;
(
    input  logic                 CLK,
    input  logic                 nRST,
    input  logic                 PIX_VALID,
    input  logic [PW-1:0]        PIX_DATA,
    output logic                 PIX_READY,
    output logic                 CNN_START,
    output logic                 WIN_VALID,
    output logic [POS_W-1:0]     X,
    output logic [POS_W-1:0]     Y,
    output logic [WIN_BITS-1:0]  IMGIN,
    input  logic                 CNN_DONE,
    output logic                 ERR
);

    localparam logic [POS_W-1:0] LAST_K = POS_W'(K - 1);
    localparam logic [POS_W-1:0] LAST_C = POS_W'(IMG_W - 1);
    localparam logic [POS_W-1:0] LAST_R = POS_W'(IMG_H - 1);
    localparam logic [POS_W-1:0] ONE    = POS_W'(1);

    state_t                 state;
    logic [POS_W-1:0]       row;
    logic [POS_W-1:0]       col;
    logic [WIN_BITS-1:0]    win_q;
    logic [WIN_BITS-1:0]    win_d;
    logic [(K-1)*PW-1:0]    taps;
    logic                   accept;
    logic                   emit;

    assign PIX_READY = (state != WAIT_DONE);
    assign accept    = PIX_VALID && PIX_READY;
    assign emit      = accept && (row >= LAST_K) && (col >= LAST_K);

    line_buffer u_line_buffer (
        .CLK  (CLK),
        .we   (accept),
        .col  (col),
        .pix  (PIX_DATA),
        .taps (taps)
    );

    // Window shifted left one column with the new column entering at l=K-1
    always_comb begin
        win_d = win_q;
        for (int k = 0; k < int'(K); k++) begin
            for (int l = 0; l < int'(K) - 1; l++) begin
                win_d[(k*K+l)*PW +: PW] = win_q[(k*K+l+1)*PW +: PW];
            end
            if (k < int'(K) - 1) begin
                win_d[(k*K+K-1)*PW +: PW] = taps[k*PW +: PW];
            end else begin
                win_d[(k*K+K-1)*PW +: PW] = PIX_DATA;
            end
        end
    end

    // Frame FSM, raster counters, window register and registered outputs
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state     <= IDLE;
            row       <= '0;
            col       <= '0;
            win_q     <= '0;
            CNN_START <= 1'b0;
            WIN_VALID <= 1'b0;
            X         <= '0;
            Y         <= '0;
            IMGIN     <= '0;
            ERR       <= 1'b0;
        end else begin
            CNN_START <= 1'b0;
            WIN_VALID <= 1'b0;
            if (CNN_DONE && (state != WAIT_DONE)) begin
                ERR <= 1'b1;
            end
            case (state)
                IDLE, LOAD: begin
                    if (accept) begin
                        win_q <= win_d;
                        if (emit) begin
                            WIN_VALID <= 1'b1;
                            X         <= row - LAST_K;
                            Y         <= col - LAST_K;
                            IMGIN     <= win_d;
                        end
                        if (state == IDLE) begin
                            CNN_START <= 1'b1;
                            state     <= LOAD;
                        end
                        if (col == LAST_C) begin
                            col <= '0;
                            if (row == LAST_R) begin
                                row   <= '0;
                                state <= WAIT_DONE;
                            end else begin
                                row <= row + ONE;
                            end
                        end else begin
                            col <= col + ONE;
                        end
                    end
                end
                WAIT_DONE: begin
                    if (CNN_DONE) begin
                        state <= IDLE;
                        row   <= '0;
                        col   <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mnist_window_feeder.sv
// Directed bench for mnist_window_feeder: frames, stalls, gaps, resets, ERR.
module tb_mnist_window_feeder;

    logic         CLK = 1'b0;
    logic         nRST;
    logic         PIX_VALID;
    logic [7:0]   PIX_DATA;
    logic         PIX_READY;
    logic         CNN_START;
    logic         WIN_VALID;
    logic [4:0]   X;
    logic [4:0]   Y;
    logic [199:0] IMGIN;
    logic         CNN_DONE;
    logic         ERR;

    int vecs = 0;
    int errs = 0;

    mnist_window_feeder dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .PIX_VALID (PIX_VALID),
        .PIX_DATA  (PIX_DATA),
        .PIX_READY (PIX_READY),
        .CNN_START (CNN_START),
        .WIN_VALID (WIN_VALID),
        .X         (X),
        .Y         (Y),
        .IMGIN     (IMGIN),
        .CNN_DONE  (CNN_DONE),
        .ERR       (ERR)
    );

    always #5 CLK = ~CLK;

    function automatic logic [7:0] pix(input int r, input int c, input logic [7:0] xr);
        int v;
        v = r * 28 + c;
        return 8'(v) ^ xr;
    endfunction

    function automatic logic [199:0] exp_win(input int x, input int y, input logic [7:0] xr);
        logic [199:0] w;
        w = '0;
        for (int k = 0; k < 5; k++)
            for (int l = 0; l < 5; l++)
                w[(k*5+l)*8 +: 8] = pix(x + k, y + l, xr);
        return w;
    endfunction

    // Drive raster pixels [start_n, end_n) with random idle cycles; check every cycle
    task automatic run_frame(input int idle_pct, input int start_n, input int end_n,
                             input logic [7:0] xr, output int nwin);
        int  r, c, n, cycles;
        bit  v, rdy, acc, exp_wv;
        n = start_n; r = n / 28; c = n % 28; nwin = 0; cycles = 0;
        while (n < end_n) begin
            v = ($urandom_range(99) >= idle_pct);
            PIX_VALID = v;
            PIX_DATA  = pix(r, c, xr);
            rdy = PIX_READY;
            @(posedge CLK); #1;
            acc    = v && rdy;
            exp_wv = acc && r >= 4 && c >= 4;
            vecs++;
            if (WIN_VALID !== exp_wv) begin
                errs++;
                $display("FAIL win_valid at r=%0d c=%0d: got %b want %b", r, c, WIN_VALID, exp_wv);
            end
            if (exp_wv && WIN_VALID) begin
                nwin++;
                vecs++;
                if (X !== 5'(r - 4) || Y !== 5'(c - 4) || IMGIN !== exp_win(r - 4, c - 4, xr)) begin
                    errs++;
                    $display("FAIL window: got X=%0d Y=%0d IMGIN=%h want X=%0d Y=%0d IMGIN=%h",
                             X, Y, IMGIN, r - 4, c - 4, exp_win(r - 4, c - 4, xr));
                end
            end
            vecs++;
            if (CNN_START !== (acc && n == 0)) begin
                errs++;
                $display("FAIL cnn_start at n=%0d: got %b want %b", n, CNN_START, acc && n == 0);
            end
            if (acc) begin
                n++;
                if (c == 27) begin c = 0; r++; end else c++;
            end
            cycles++;
            if (cycles > 20000) begin
                errs++;
                $display("FAIL frame_timeout: got %0d accepts want %0d", n, end_n);
                break;
            end
        end
        PIX_VALID = 1'b0;
    endtask

    task automatic pulse_done();
        CNN_DONE = 1'b1;
        @(posedge CLK); #1;
        CNN_DONE = 1'b0;
        vecs++;
        if (PIX_READY !== 1'b1) begin
            errs++;
            $display("FAIL ready_after_done: got %b want 1", PIX_READY);
        end
    endtask

    task automatic apply_reset();
        nRST = 1'b0;
        PIX_VALID = 1'b1;
        PIX_DATA = 8'hA5;
        repeat (2) @(posedge CLK);
        #1;
        nRST = 1'b1;
        PIX_VALID = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        vecs++;
        if (PIX_READY !== 1'b1 || CNN_START !== 1'b0 || WIN_VALID !== 1'b0 ||
            X !== 5'd0 || Y !== 5'd0 || IMGIN !== 200'd0 || ERR !== 1'b0) begin
            errs++;
            $display("FAIL reset_state: got rdy=%b st=%b wv=%b X=%0d Y=%0d IMGIN=%h ERR=%b want 1 0 0 0 0 0 0",
                     PIX_READY, CNN_START, WIN_VALID, X, Y, IMGIN, ERR);
        end
    endtask

    task automatic test_frame();
        int nwin;
        run_frame(0, 0, 784, 8'h00, nwin);
        vecs++;
        if (nwin != 576) begin
            errs++;
            $display("FAIL frame_count: got %0d want 576", nwin);
        end
        vecs++;
        if (IMGIN[7:0] !== 8'h9B || IMGIN[199:192] !== 8'h0F || X !== 5'd23 || Y !== 5'd23) begin
            errs++;
            $display("FAIL last_window: got X=%0d Y=%0d lo=%h hi=%h want 23 23 9b 0f",
                     X, Y, IMGIN[7:0], IMGIN[199:192]);
        end
    endtask

    task automatic test_wait_done();
        int nwin;
        PIX_VALID = 1'b1;
        PIX_DATA  = 8'h55;
        for (int i = 0; i < 50; i++) begin
            @(posedge CLK); #1;
            vecs++;
            if (PIX_READY !== 1'b0 || WIN_VALID !== 1'b0) begin
                errs++;
                $display("FAIL wait_stall cycle %0d: got rdy=%b wv=%b want 0 0", i, PIX_READY, WIN_VALID);
            end
        end
        PIX_VALID = 1'b0;
        pulse_done();
        vecs++;
        if (ERR !== 1'b0) begin
            errs++;
            $display("FAIL err_done_in_wait: got %b want 0", ERR);
        end
        run_frame(0, 0, 784, 8'h00, nwin);
        vecs++;
        if (nwin != 576) begin
            errs++;
            $display("FAIL second_frame_count: got %0d want 576", nwin);
        end
    endtask

    task automatic test_gaps();
        int nwin;
        pulse_done();
        run_frame(30, 0, 784, 8'h00, nwin);
        vecs++;
        if (nwin != 576) begin
            errs++;
            $display("FAIL gaps_count: got %0d want 576", nwin);
        end
    endtask

    task automatic test_reset_mid();
        int nwin;
        pulse_done();
        run_frame(0, 0, 300, 8'hFF, nwin);
        apply_reset();
        vecs++;
        if (PIX_READY !== 1'b1 || WIN_VALID !== 1'b0 || ERR !== 1'b0) begin
            errs++;
            $display("FAIL mid_reset_state: got rdy=%b wv=%b err=%b want 1 0 0", PIX_READY, WIN_VALID, ERR);
        end
        run_frame(0, 0, 784, 8'h00, nwin);
        vecs++;
        if (nwin != 576 || ERR !== 1'b0) begin
            errs++;
            $display("FAIL mid_reset_frame: got %0d windows err=%b want 576 0", nwin, ERR);
        end
    endtask

    task automatic test_err();
        int nwin;
        pulse_done();
        run_frame(0, 0, 100, 8'h00, nwin);
        CNN_DONE = 1'b1;
        @(posedge CLK); #1;
        CNN_DONE = 1'b0;
        vecs++;
        if (ERR !== 1'b1 || PIX_READY !== 1'b1) begin
            errs++;
            $display("FAIL err_set: got err=%b rdy=%b want 1 1", ERR, PIX_READY);
        end
        run_frame(30, 100, 784, 8'h00, nwin);
        vecs++;
        if (nwin != 576 || ERR !== 1'b1) begin
            errs++;
            $display("FAIL err_frame: got %0d windows err=%b want 576 1", nwin, ERR);
        end
        pulse_done();
        run_frame(0, 0, 784, 8'h00, nwin);
        vecs++;
        if (nwin != 576 || ERR !== 1'b1) begin
            errs++;
            $display("FAIL err_next_frame: got %0d windows err=%b want 576 1", nwin, ERR);
        end
        apply_reset();
        vecs++;
        if (ERR !== 1'b0) begin
            errs++;
            $display("FAIL err_cleared: got %b want 0", ERR);
        end
    endtask

    initial begin
        nRST      = 1'b0;
        PIX_VALID = 1'b0;
        PIX_DATA  = 8'h00;
        CNN_DONE  = 1'b0;
        test_reset();
        test_frame();
        test_wait_done();
        test_gaps();
        test_reset_mid();
        test_err();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
